clb_lut_chain: RTL and testbench

//  Parametrised successor to the fixed-function CLB, for the FPGA tile array. K-input LUT; each LUT input

---
 rtl/clb_lut_chain.sv | 132 +++++++++++++
 tb/tb_clb_lut_chain.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clb_lut_chain.sv
`default_nettype none
// clb_lut_chain: K-input LUT tile with neighbour/local source muxes, optional output FF, 4-way routing
// and a daisy-chained serial configuration load. Optional build macro: CLB_CFG_PARITY_EN (even-parity MSB).
module clb_lut_chain #(
  parameter int LUT_K   = 4,
  parameter int N_LOCAL = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               from_north,
  input  logic               from_south,
  input  logic               from_east,
  input  logic               from_west,
  input  logic [N_LOCAL-1:0] local_inputs,
  input  logic               ce_i,
  input  logic               cfg_en_i,
  input  logic               cfg_data_i,
  output logic               cfg_data_o,
  output logic               cfg_done_o,
  output logic               cfg_err_o,
  output logic               to_north,
  output logic               to_south,
  output logic               to_east,
  output logic               to_west,
  output logic               local_output
);

  localparam int SRC_N      = 4 + N_LOCAL + 1;
  localparam int SELW       = $clog2(SRC_N + 1);
  localparam int SRC_PAD    = (1 << SELW) - SRC_N;
  localparam int LUT_N      = 1 << LUT_K;
  localparam int CFG_W      = LUT_K * SELW + LUT_N + 6;
  localparam int LUT_LO     = LUT_K * SELW;
  localparam int ROUTE_LO   = LUT_LO + LUT_N;
  localparam int FFUSE_BIT  = ROUTE_LO + 4;
  localparam int FFINIT_BIT = FFUSE_BIT + 1;
`ifdef CLB_CFG_PARITY_EN
  localparam int CHAIN_W    = CFG_W + 1;
`else
  localparam int CHAIN_W    = CFG_W;
`endif
  localparam int CNT_W      = $clog2(CHAIN_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_W + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, RUN = 2'd2} state_t;

  state_t             state;
  logic [CHAIN_W-1:0] cfg_q;
  logic [CNT_W-1:0]   cnt;
  logic               ff_q;
  logic               cfg_err;

  logic [(1<<SELW)-1:0] src_ext;
  logic [LUT_K-1:0]     lut_in;
  logic [LUT_N-1:0]     lut_bits;
  logic [3:0]           route;
  logic                 lut_out;
  logic                 func;
  logic                 active;
  logic                 parity_ok;

  // Unused select codes land on the zero padding, so they read as constant 0.
  assign src_ext  = {{SRC_PAD{1'b0}}, ff_q, local_inputs, from_west, from_east, from_south, from_north};
  assign lut_bits = cfg_q[LUT_LO +: LUT_N];
  assign route    = cfg_q[ROUTE_LO +: 4];

  for (genvar i = 0; i < LUT_K; i++) begin : g_lut_in
    logic [SELW-1:0] sel;
    assign sel       = cfg_q[i*SELW +: SELW];
    assign lut_in[i] = src_ext[sel];
  end

  assign lut_out = lut_bits[lut_in];
  assign func    = cfg_q[FFUSE_BIT] ? ff_q : lut_out;

`ifdef CLB_CFG_PARITY_EN
  assign parity_ok = ~^cfg_q;
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cfg_q   <= '0;
      cnt     <= '0;
      ff_q    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      if (cfg_en_i) begin
        cfg_q <= {cfg_data_i, cfg_q[CHAIN_W-1:1]};
      end
      case (state)
        IDLE, RUN: begin
          if (cfg_en_i) begin
            state   <= SHIFT;
            cnt     <= CNT_W'(1);
            cfg_err <= 1'b0;
          end else if (state == RUN && ce_i) begin
            ff_q <= lut_out;
          end
        end
        SHIFT: begin
          if (cfg_en_i) begin
            if (cnt != CNT_SAT) cnt <= cnt + CNT_W'(1);
          end else if (cnt == CNT_FULL && parity_ok) begin
            state <= RUN;
            ff_q  <= cfg_q[FFINIT_BIT];
          end else begin
            state   <= IDLE;
            cfg_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A new load starting from RUN must silence the tile in the same cycle, before the state changes.
  assign active       = (state == RUN) && !cfg_en_i;
  assign local_output = active & func;
  assign to_north     = active & func & route[0];
  assign to_south     = active & func & route[1];
  assign to_east      = active & func & route[2];
  assign to_west      = active & func & route[3];
  assign cfg_done_o   = (state == RUN);
  assign cfg_err_o    = cfg_err;
  assign cfg_data_o   = cfg_q[0];

endmodule
`default_nettype wire

// File: tb/tb_clb_lut_chain.sv
`default_nettype none
// tb_clb_lut_chain: directed bench with a bit-history reference model checked every cycle.
module tb_clb_lut_chain;
  localparam int K = 4, SELW = 3, CFG_W = 34;
`ifdef CLB_CFG_PARITY_EN
  localparam int CHAIN_W = CFG_W + 1;
`else
  localparam int CHAIN_W = CFG_W;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic fn = 1'b0, fs = 1'b0, fe = 1'b0, fw = 1'b0;
  logic [1:0] loc = 2'b00;
  logic ce = 1'b0, cfg_en = 1'b0, cfg_din = 1'b0;
  logic cfg_dout, cfg_done, cfg_err, to_n, to_s, to_e, to_w, lout;

  int errors = 0, checks = 0;

  clb_lut_chain #(.LUT_K(4), .N_LOCAL(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .from_north(fn), .from_south(fs), .from_east(fe), .from_west(fw),
    .local_inputs(loc), .ce_i(ce), .cfg_en_i(cfg_en), .cfg_data_i(cfg_din),
    .cfg_data_o(cfg_dout), .cfg_done_o(cfg_done), .cfg_err_o(cfg_err),
    .to_north(to_n), .to_south(to_s), .to_east(to_e), .to_west(to_w),
    .local_output(lout)
  );

  always #5 clk = ~clk;

  // Reference model: every bit shifted since reset, the current burst length and run/err/ff flags.
  bit hist[$];
  int burst = 0;
  bit m_shift = 0, m_run = 0, m_err = 0, m_ff = 0, chk_on = 0;

  function automatic bit img(input int j);
    int p;
    p = hist.size() - CHAIN_W + j;
    return (p >= 0) ? hist[p] : 1'b0;
  endfunction

  function automatic int field(input int lo, input int w);
    int v = 0;
    for (int b = 0; b < w; b++) v += int'(img(lo + b)) << b;
    return v;
  endfunction

  function automatic bit src(input int code);
    case (code)
      0: return fn;
      1: return fs;
      2: return fe;
      3: return fw;
      4: return loc[0];
      5: return loc[1];
      6: return m_ff;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit lut_model();
    int idx = 0;
    for (int i = 0; i < K; i++) idx += int'(src(field(i*SELW, SELW))) << i;
    return img(12 + idx);
  endfunction

  function automatic logic [7:0] model_vec();
    bit f, act;
    f   = img(32) ? m_ff : lut_model();
    act = m_run && !cfg_en;
    return {act & f, act & f & img(28), act & f & img(29), act & f & img(30), act & f & img(31),
            m_run, m_err, img(0)};
  endfunction

  function automatic bit parity_ok();
`ifdef CLB_CFG_PARITY_EN
    bit p = 0;
    for (int j = 0; j < CHAIN_W; j++) p ^= img(j);
    return !p;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_edge();
    bit nxt;
    if (rst) begin
      hist.delete();
      burst = 0; m_shift = 0; m_run = 0; m_err = 0; m_ff = 0; chk_on = 1;
    end else if (cfg_en) begin
      if (!m_shift) begin
        m_shift = 1; m_run = 0; m_err = 0; burst = 0;
      end
      burst++;
      hist.push_back(cfg_din);
    end else if (m_shift) begin
      m_shift = 0;
      if (burst == CHAIN_W && parity_ok()) begin
        m_run = 1; m_ff = img(33);
      end else begin
        m_err = 1;
      end
    end else if (m_run && ce) begin
      nxt = lut_model();
      m_ff = nxt;
    end
  endtask

  task automatic chk(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare DUT with model mid-cycle, then advance model at the edge.
  task automatic cyc(input bit en, input bit din, input bit c);
    logic [7:0] got, exp;
    cfg_en = en; cfg_din = din; ce = c;
    @(negedge clk);
    if (chk_on) begin
      got = {lout, to_n, to_s, to_e, to_w, cfg_done, cfg_err, cfg_dout};
      exp = model_vec();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL cycle: got %b expected %b at %0t", got, exp, $time);
      end
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [CHAIN_W-1:0] mk(input int s0, input int s1, input int s2, input int s3,
                                             input logic [15:0] lut, input logic [3:0] route,
                                             input bit ffu, input bit ffi);
    logic [CHAIN_W-1:0] v;
    v = '0;
    v[0 +: 3] = 3'(s0);
    v[3 +: 3] = 3'(s1);
    v[6 +: 3] = 3'(s2);
    v[9 +: 3] = 3'(s3);
    v[12 +: 16] = lut;
    v[28 +: 4] = route;
    v[32] = ffu;
    v[33] = ffi;
`ifdef CLB_CFG_PARITY_EN
    v[CFG_W] = ^v[CFG_W-1:0];
`endif
    return v;
  endfunction

  task automatic shift_bits(input logic [CHAIN_W-1:0] v, input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, v[i], 1'b0);
  endtask

  logic [CHAIN_W-1:0] t1, t2, bad;
  bit rbits[68];

  initial begin
    t1 = mk(4, 5, 7, 7, 16'h0008, 4'b0001, 1'b0, 1'b0);
    t2 = mk(6, 7, 7, 7, 16'h5555, 4'b0100, 1'b1, 1'b0);

    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("rst_done", cfg_done, 1'b0);
    chk("rst_err", cfg_err, 1'b0);
    chk("rst_dout", cfg_dout, 1'b0);
    chk("rst_lout", lout, 1'b0);
    rst = 1'b0;
    cyc(0, 0, 0);

    // AND of the two local inputs routed north
    shift_bits(t1, CHAIN_W);
    cyc(0, 0, 0);
    loc = 2'b11; fs = 1'b1; #1;
    chk("t1_done", cfg_done, 1'b1);
    chk("t1_north", to_n, 1'b1);
    chk("t1_lout", lout, 1'b1);
    chk("t1_south", to_s, 1'b0);
    chk("t1_east", to_e, 1'b0);
    loc = 2'b01; #1;
    chk("t1_north01", to_n, 1'b0);
    chk("t1_lout01", lout, 1'b0);
    cyc(0, 0, 1);
    loc = 2'b10;
    cyc(0, 0, 0);

    // Toggle flop through its own feedback, routed east
    shift_bits(t2, CHAIN_W);
    cyc(0, 0, 0);
    chk("t2_init", to_e, 1'b0);
    cyc(0, 0, 1); chk("t2_e1", to_e, 1'b1);
    cyc(0, 0, 1); chk("t2_e2", to_e, 1'b0);
    cyc(0, 0, 1); chk("t2_e3", to_e, 1'b1);
    cyc(0, 0, 1); chk("t2_e4", to_e, 1'b0);
    cyc(0, 0, 1); chk("t2_e5", to_e, 1'b1);
    cyc(0, 0, 0); chk("t2_hold1", to_e, 1'b1);
    cyc(0, 0, 0); chk("t2_hold2", to_e, 1'b1);
    chk("t2_north", to_n, 1'b0);
    cfg_en = 1'b1; #1;
    chk("gate_east", to_e, 1'b0);
    chk("gate_done", cfg_done, 1'b1);

    // Short load, then a full load recovers
    loc = 2'b11;
    shift_bits(t1, CHAIN_W - 1);
    cyc(0, 0, 0);
    chk("t3_err", cfg_err, 1'b1);
    chk("t3_done", cfg_done, 1'b0);
    chk("t3_lout", lout, 1'b0);
    chk("t3_north", to_n, 1'b0);
    shift_bits(t1, CHAIN_W);
    cyc(0, 0, 0);
    chk("t3_err_clr", cfg_err, 1'b0);
    chk("t3_done_ok", cfg_done, 1'b1);
    chk("t3_north_ok", to_n, 1'b1);

    // Reset in the middle of a load
    shift_bits(t1, 10);
    rst = 1'b1;
    cyc(0, 0, 0);
    chk("t4_done", cfg_done, 1'b0);
    chk("t4_err", cfg_err, 1'b0);
    chk("t4_dout", cfg_dout, 1'b0);
    chk("t4_lout", lout, 1'b0);
    rst = 1'b0;
    cyc(0, 0, 0);

    // Chain pass-through delay and over-length load
    for (int i = 0; i < 68; i++) rbits[i] = 1'($urandom_range(0, 1));
    rbits[34] = ~rbits[33];
    for (int m = 0; m < 68; m++) begin
      cyc(1, rbits[m], 0);
      if (m >= CHAIN_W - 1) chk("t5_chain", cfg_dout, rbits[m - CHAIN_W + 1]);
    end
    cyc(0, 0, 0);
    chk("t5_err", cfg_err, 1'b1);
    chk("t5_done", cfg_done, 1'b0);

`ifdef CLB_CFG_PARITY_EN
    shift_bits(t1, CHAIN_W);
    cyc(0, 0, 0);
    chk("t6_done", cfg_done, 1'b1);
    chk("t6_err", cfg_err, 1'b0);
    bad = t1;
    bad[CFG_W] = ~bad[CFG_W];
    shift_bits(bad, CHAIN_W);
    cyc(0, 0, 0);
    chk("t6_bad_done", cfg_done, 1'b0);
    chk("t6_bad_err", cfg_err, 1'b1);
`else
    bad = '0;
`endif
    cyc(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
